// File: rtl/nim_turn_ctrl_pkg.sv
// Shared definitions for the nim turn sequencer: FSM state encoding, pile
// geometry, game_end codes and small pile helper functions.
package nim_turn_ctrl_pkg;

  localparam int PILE_W     = 4;
  localparam int ROW_OFFSET = 5;
  localparam int MAX_PILES  = 5;
  localparam int NUM_SLOTS  = 2 * ROW_OFFSET;
  localparam int STATUS_W   = PILE_W * NUM_SLOTS;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_PICK_SRC,
    ST_PICK_DST,
    ST_APPLY,
    ST_CHECK,
    ST_END
  } state_t;

  typedef enum logic [1:0] {
    GE_RUN  = 2'd0,
    GE_P0   = 2'd1,
    GE_P1   = 2'd2,
    GE_DRAW = 2'd3
  } game_end_t;

  // 5-bit sum so 9+9 cannot overflow before the -10 fold.
  function automatic logic [PILE_W-1:0] add_mod10(input logic [PILE_W-1:0] a,
                                                  input logic [PILE_W-1:0] b);
    logic [PILE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[PILE_W-1:0];
  endfunction

  function automatic logic [PILE_W-1:0] pile_at(input logic [STATUS_W-1:0] st,
                                                input logic [IDX_W-1:0]    idx);
    logic [PILE_W-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_SLOTS; p++)
      if (idx == IDX_W'(p)) v = st[p*PILE_W +: PILE_W];
    return v;
  endfunction

  function automatic logic [STATUS_W-1:0] set_pile(input logic [STATUS_W-1:0] st,
                                                   input logic [IDX_W-1:0]    idx,
                                                   input logic [PILE_W-1:0]   val);
    logic [STATUS_W-1:0] r;
    r = st;
    for (int p = 0; p < NUM_SLOTS; p++)
      if (idx == IDX_W'(p)) r[p*PILE_W +: PILE_W] = val;
    return r;
  endfunction

  function automatic logic [STATUS_W-1:0] init_status(input int n_piles, input int init_value);
    logic [STATUS_W-1:0] st;
    st = '0;
    for (int p = 0; p < MAX_PILES; p++) begin
      if (p < n_piles) begin
        st[p*PILE_W +: PILE_W]              = PILE_W'(init_value);
        st[(p+ROW_OFFSET)*PILE_W +: PILE_W] = PILE_W'(init_value);
      end
    end
    return st;
  endfunction

endpackage

// File: rtl/nim_cursor.sv
// Row-wrapping cursor step for the nim turn sequencer.
// Ports:
//   index      current pile index
//   base       first pile index of the row the cursor lives in
//   left/right one-hot move request (left wins if both are set)
//   next_index resulting pile index, always inside base..base+N_PILES-1
module nim_cursor
  import nim_turn_ctrl_pkg::*;
#(
  parameter int N_PILES = 5
) (
  input  logic [IDX_W-1:0] index,
  input  logic [IDX_W-1:0] base,
  input  logic             left,
  input  logic             right,
  output logic [IDX_W-1:0] next_index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PILES - 1);

  logic [IDX_W-1:0] offset;

  always_comb begin
    offset     = index - base;
    next_index = index;
    if (left)
      next_index = (offset == '0) ? base + LAST : index - 1'b1;
    else if (right)
      next_index = (offset == LAST) ? base : index + 1'b1;
  end

endmodule

// File: rtl/nim_turn_ctrl.sv
// Turn sequencer for the two-row add-mod-10 duel. Player 0 owns piles 0..4,
// player 1 owns piles 5..9. Handles cursor, source/target selection, move
// application, win detection and drives the renderer state inputs.
// Optional build macro: GAME_MOVE_LIMIT_EN (move counter forcing a draw at
// MOVE_LIMIT non-winning moves).
// Ports:
//   vga_clk, vga_rst_n      pixel clock, async active-low reset
//   btn_left/right/confirm/cancel/restart   one-cycle button pulses
//   total_number            N_PILES
//   status                  pile p at [4p+3:4p]
//   cur_player              player to move
//   cur_select / selected   cursor / source pile index x4
//   selecting               a source pile is held
//   predict                 value the target would take
//   game_end                0 running, 1 p0 won, 2 p1 won, 3 draw
//
// state       | meaning
// ST_PICK_SRC | cursor in own row, waiting for a nonzero source
// ST_PICK_DST | cursor in opponent row, waiting for a nonzero target
// ST_APPLY    | write (src + target) mod 10 into the target
// ST_CHECK    | win/draw test, then hand the turn over
// ST_END      | game over, only restart acts
module nim_turn_ctrl
  import nim_turn_ctrl_pkg::*;
#(
  parameter int N_PILES    = 5,
  parameter int INIT_VALUE = 1,
  parameter int MOVE_LIMIT = 99
) (
  input  logic                vga_clk,
  input  logic                vga_rst_n,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_confirm,
  input  logic                btn_cancel,
  input  logic                btn_restart,
  output logic [31:0]         total_number,
  output logic [STATUS_W-1:0] status,
  output logic                cur_player,
  output logic [31:0]         cur_select,
  output logic [31:0]         selected,
  output logic                selecting,
  output logic [PILE_W-1:0]   predict,
  output logic [1:0]          game_end
);

  if (N_PILES < 1 || N_PILES > MAX_PILES || INIT_VALUE < 1 || INIT_VALUE > 9 ||
      MOVE_LIMIT < 1 || MOVE_LIMIT > 255) begin : g_bad_param
    $error("nim_turn_ctrl: parameter out of range");
  end

  localparam logic [STATUS_W-1:0] INIT_STATUS = init_status(N_PILES, INIT_VALUE);

  state_t              state_q, state_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                player_q, player_d;
  logic [IDX_W-1:0]    cursor_q, cursor_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic                selecting_q, selecting_d;
  game_end_t           game_end_q, game_end_d;

  logic do_restart, do_cancel, do_confirm, do_left, do_right;
  logic [IDX_W-1:0]  own_base, opp_base, row_base, cursor_mv;
  logic [PILE_W-1:0] cur_val, src_val;
  logic              opp_clear, draw_hit;

  // Only the highest-priority pulse acts in a cycle.
  assign do_restart = btn_restart;
  assign do_cancel  = !btn_restart && btn_cancel;
  assign do_confirm = !btn_restart && !btn_cancel && btn_confirm;
  assign do_left    = !btn_restart && !btn_cancel && !btn_confirm && btn_left;
  assign do_right   = !btn_restart && !btn_cancel && !btn_confirm && !btn_left && btn_right;

  assign own_base = player_q ? IDX_W'(ROW_OFFSET) : '0;
  assign opp_base = player_q ? '0 : IDX_W'(ROW_OFFSET);
  // While picking a target the cursor wraps within the opponent row.
  assign row_base = (state_q == ST_PICK_DST) ? opp_base : own_base;
  assign cur_val  = pile_at(status_q, cursor_q);
  assign src_val  = pile_at(status_q, sel_q);

  nim_cursor #(.N_PILES(N_PILES)) u_cursor (
    .index      (cursor_q),
    .base       (row_base),
    .left       (do_left),
    .right      (do_right),
    .next_index (cursor_mv)
  );

  always_comb begin
    opp_clear = 1'b1;
    for (int p = 0; p < MAX_PILES; p++)
      if (p < N_PILES && pile_at(status_q, opp_base + IDX_W'(p)) != '0) opp_clear = 1'b0;
  end

`ifdef GAME_MOVE_LIMIT_EN
  localparam logic [7:0] LIMIT_CNT = 8'(MOVE_LIMIT);
  logic [7:0] move_cnt_q;

  assign draw_hit = (move_cnt_q + 8'd1) == LIMIT_CNT;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n)
      move_cnt_q <= '0;
    else if (do_restart)
      move_cnt_q <= '0;
    else if (state_q == ST_CHECK && !opp_clear)
      move_cnt_q <= move_cnt_q + 8'd1;
  end
`else
  assign draw_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    player_d    = player_q;
    cursor_d    = cursor_q;
    sel_d       = sel_q;
    selecting_d = selecting_q;
    game_end_d  = game_end_q;
    if (do_restart) begin
      state_d     = ST_PICK_SRC;
      status_d    = INIT_STATUS;
      player_d    = 1'b0;
      cursor_d    = '0;
      sel_d       = '0;
      selecting_d = 1'b0;
      game_end_d  = GE_RUN;
    end else begin
      case (state_q)
        ST_PICK_SRC: begin
          if (do_confirm) begin
            if (cur_val != '0) begin
              sel_d       = cursor_q;
              selecting_d = 1'b1;
              cursor_d    = opp_base;
              state_d     = ST_PICK_DST;
            end
          end else if (do_left || do_right) begin
            cursor_d = cursor_mv;
          end
        end
        ST_PICK_DST: begin
          if (do_cancel) begin
            selecting_d = 1'b0;
            cursor_d    = sel_q;
            state_d     = ST_PICK_SRC;
          end else if (do_confirm) begin
            if (cur_val != '0) state_d = ST_APPLY;
          end else if (do_left || do_right) begin
            cursor_d = cursor_mv;
          end
        end
        ST_APPLY: begin
          status_d = set_pile(status_q, cursor_q, add_mod10(src_val, cur_val));
          state_d  = ST_CHECK;
        end
        ST_CHECK: begin
          if (opp_clear) begin
            game_end_d = player_q ? GE_P1 : GE_P0;
            state_d    = ST_END;
          end else if (draw_hit) begin
            game_end_d = GE_DRAW;
            state_d    = ST_END;
          end else begin
            player_d    = !player_q;
            selecting_d = 1'b0;
            cursor_d    = opp_base;
            state_d     = ST_PICK_SRC;
          end
        end
        ST_END:  ;
        default: state_d = ST_PICK_SRC;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      state_q     <= ST_PICK_SRC;
      status_q    <= INIT_STATUS;
      player_q    <= 1'b0;
      cursor_q    <= '0;
      sel_q       <= '0;
      selecting_q <= 1'b0;
      game_end_q  <= GE_RUN;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      player_q    <= player_d;
      cursor_q    <= cursor_d;
      sel_q       <= sel_d;
      selecting_q <= selecting_d;
      game_end_q  <= game_end_d;
    end
  end

  assign total_number = 32'(N_PILES);
  assign status       = status_q;
  assign cur_player   = player_q;
  assign cur_select   = 32'({cursor_q, 2'b00});
  assign selected     = 32'({sel_q, 2'b00});
  assign selecting    = selecting_q;
  assign predict      = (state_q == ST_PICK_DST && cur_val != '0) ? add_mod10(src_val, cur_val) : '0;
  assign game_end     = game_end_q;

endmodule

// File: tb/tb_nim_turn_ctrl.sv
// Scoreboard bench for nim_turn_ctrl. Three instances: N=5/INIT=1 (move
// limit 2), N=2/INIT=5 and N=1/INIT=5.
module tb_nim_turn_ctrl;

  typedef enum int {S_STATUS, S_PLAYER, S_CSEL, S_SEL, S_SELING, S_PRED, S_GE, S_TOTAL} sig_e;

  typedef struct {
    string       tag;
    int          inst;
    sig_e        sig;
    logic [39:0] exp;
  } exp_t;

  localparam logic [4:0] K_RS = 5'b10000;
  localparam logic [4:0] K_CN = 5'b01000;
  localparam logic [4:0] K_CF = 5'b00100;
  localparam logic [4:0] K_L  = 5'b00010;
  localparam logic [4:0] K_R  = 5'b00001;

  logic vga_clk = 1'b0;
  logic vga_rst_n = 1'b0;
  logic b_l[3], b_r[3], b_cf[3], b_cn[3], b_rs[3];
  logic [31:0] tot[3], cs[3], sel[3];
  logic [39:0] st[3];
  logic        cp[3], sing[3];
  logic [3:0]  pred[3];
  logic [1:0]  ge[3];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nim_turn_ctrl #(
      .N_PILES    (g == 0 ? 5 : (g == 1 ? 2 : 1)),
      .INIT_VALUE (g == 0 ? 1 : 5),
      .MOVE_LIMIT (g == 0 ? 2 : 99)
    ) u_dut (
      .vga_clk      (vga_clk),
      .vga_rst_n    (vga_rst_n),
      .btn_left     (b_l[g]),
      .btn_right    (b_r[g]),
      .btn_confirm  (b_cf[g]),
      .btn_cancel   (b_cn[g]),
      .btn_restart  (b_rs[g]),
      .total_number (tot[g]),
      .status       (st[g]),
      .cur_player   (cp[g]),
      .cur_select   (cs[g]),
      .selected     (sel[g]),
      .selecting    (sing[g]),
      .predict      (pred[g]),
      .game_end     (ge[g])
    );
  end

  task automatic check_val(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [39:0] sample(input int i, input sig_e s);
    case (s)
      S_STATUS: return st[i];
      S_PLAYER: return 40'(cp[i]);
      S_CSEL:   return 40'(cs[i]);
      S_SEL:    return 40'(sel[i]);
      S_SELING: return 40'(sing[i]);
      S_PRED:   return 40'(pred[i]);
      S_GE:     return 40'(ge[i]);
      default:  return 40'(tot[i]);
    endcase
  endfunction

  task automatic sb_push(input string tag, input int i, input sig_e s, input logic [39:0] v);
    exp_t e;
    e.tag = tag; e.inst = i; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, sample(e.inst, e.sig), e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  // Pulse for exactly one rising edge; returns at the negedge after it.
  task automatic press(input int i, input logic [4:0] m);
    @(negedge vga_clk);
    b_rs[i] = m[4]; b_cn[i] = m[3]; b_cf[i] = m[2]; b_l[i] = m[1]; b_r[i] = m[0];
    @(negedge vga_clk);
    b_rs[i] = 1'b0; b_cn[i] = 1'b0; b_cf[i] = 1'b0; b_l[i] = 1'b0; b_r[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      b_l[i] = 0; b_r[i] = 0; b_cf[i] = 0; b_cn[i] = 0; b_rs[i] = 0;
    end
    cyc(3);
    vga_rst_n = 1'b1;

    sb_push("rst0_status", 0, S_STATUS, 40'h11111_11111);
    sb_push("rst0_csel", 0, S_CSEL, 0);
    sb_push("rst0_seling", 0, S_SELING, 0);
    sb_push("rst0_ge", 0, S_GE, 0);
    sb_push("rst0_player", 0, S_PLAYER, 0);
    sb_push("rst0_pred", 0, S_PRED, 0);
    sb_push("rst0_total", 0, S_TOTAL, 5);
    sb_push("rst1_status", 1, S_STATUS, 40'h00055_00055);
    sb_push("rst1_total", 1, S_TOTAL, 2);
    sb_push("rst2_status", 2, S_STATUS, 40'h00005_00005);
    sb_push("rst2_total", 2, S_TOTAL, 1);
    drain();

    // ---- instance 0: cursor wrap, select, cancel, move, priority ----
    sb_push("wrap_left", 0, S_CSEL, 16);        press(0, K_L);  drain();
    sb_push("wrap_right", 0, S_CSEL, 0);        press(0, K_R);  drain();
    sb_push("src_sel", 0, S_SEL, 0);
    sb_push("src_seling", 0, S_SELING, 1);
    sb_push("src_csel", 0, S_CSEL, 20);
    sb_push("src_pred", 0, S_PRED, 2);          press(0, K_CF); drain();
    sb_push("dst_right", 0, S_CSEL, 24);
    sb_push("dst_pred", 0, S_PRED, 2);          press(0, K_R);  drain();
    sb_push("cancel_csel", 0, S_CSEL, 0);
    sb_push("cancel_seling", 0, S_SELING, 0);
    sb_push("cancel_pred", 0, S_PRED, 0);       press(0, K_CN); drain();
    sb_push("resel_csel", 0, S_CSEL, 20);       press(0, K_CF); drain();
    sb_push("resel_right", 0, S_CSEL, 24);      press(0, K_R);  drain();
    sb_push("apply_pending", 0, S_STATUS, 40'h11111_11111);
    sb_push("apply_pred0", 0, S_PRED, 0);       press(0, K_CF); drain();
    sb_push("apply_status", 0, S_STATUS, 40'h11121_11111);
    sb_push("apply_player", 0, S_PLAYER, 0);    cyc(1); drain();
    sb_push("check_player", 0, S_PLAYER, 1);
    sb_push("check_csel", 0, S_CSEL, 20);
    sb_push("check_seling", 0, S_SELING, 0);
    sb_push("check_ge", 0, S_GE, 0);            cyc(1); drain();
    sb_push("prio_left_right", 0, S_CSEL, 36);  press(0, K_L | K_R); drain();
    sb_push("prio_cf_l_sel", 0, S_SEL, 36);
    sb_push("prio_cf_l_csel", 0, S_CSEL, 0);
    sb_push("prio_cf_l_pred", 0, S_PRED, 2);    press(0, K_CF | K_L); drain();
    sb_push("prio_cn_cf_csel", 0, S_CSEL, 36);
    sb_push("prio_cn_cf_seling", 0, S_SELING, 0); press(0, K_CN | K_CF); drain();
    sb_push("p1_wrap_right", 0, S_CSEL, 20);    press(0, K_R); drain();
    sb_push("restart_status", 0, S_STATUS, 40'h11111_11111);
    sb_push("restart_player", 0, S_PLAYER, 0);
    sb_push("restart_csel", 0, S_CSEL, 0);
    sb_push("restart_ge", 0, S_GE, 0);          press(0, K_RS | K_CN | K_CF); drain();

    // two non-winning moves: draw only with the move limit built in
    press(0, K_CF); press(0, K_CF); cyc(2);
    sb_push("lim_m1_ge", 0, S_GE, 0);
    sb_push("lim_m1_player", 0, S_PLAYER, 1);   drain();
    press(0, K_CF); press(0, K_CF); cyc(2);
    sb_push("lim_m2_status", 0, S_STATUS, 40'h11112_11113);
`ifdef GAME_MOVE_LIMIT_EN
    sb_push("lim_m2_ge", 0, S_GE, 3);
    sb_push("lim_m2_player", 0, S_PLAYER, 1);
`else
    sb_push("lim_m2_ge", 0, S_GE, 0);
    sb_push("lim_m2_player", 0, S_PLAYER, 0);
`endif
    drain();

    // ---- instance 1: zero source/target ignored, win, END, restart ----
    sb_push("n2_src_csel", 1, S_CSEL, 20);
    sb_push("n2_src_pred", 1, S_PRED, 0);       press(1, K_CF); drain();
    press(1, K_CF); cyc(2);
    sb_push("n2_m1_status", 1, S_STATUS, 40'h00050_00055);
    sb_push("n2_m1_player", 1, S_PLAYER, 1);
    sb_push("n2_m1_ge", 1, S_GE, 0);            drain();
    sb_push("n2_zero_src_seling", 1, S_SELING, 0);
    sb_push("n2_zero_src_csel", 1, S_CSEL, 20); press(1, K_CF); drain();
    sb_push("n2_right", 1, S_CSEL, 24);         press(1, K_R);  drain();
    sb_push("n2_src2_sel", 1, S_SEL, 24);
    sb_push("n2_src2_csel", 1, S_CSEL, 0);      press(1, K_CF); drain();
    press(1, K_CF); cyc(2);
    sb_push("n2_m2_status", 1, S_STATUS, 40'h00050_00050);
    sb_push("n2_m2_player", 1, S_PLAYER, 0);    drain();
    sb_push("n2_zero_src2", 1, S_SELING, 0);    press(1, K_CF); drain();
    sb_push("n2_left_wrap", 1, S_CSEL, 4);      press(1, K_L);  drain();
    sb_push("n2_src3_sel", 1, S_SEL, 4);
    sb_push("n2_src3_csel", 1, S_CSEL, 20);     press(1, K_CF); drain();
    sb_push("n2_zero_dst_csel", 1, S_CSEL, 20);
    sb_push("n2_zero_dst_seling", 1, S_SELING, 1);
    sb_push("n2_zero_dst_status", 1, S_STATUS, 40'h00050_00050); press(1, K_CF); drain();
    sb_push("n2_dst_right", 1, S_CSEL, 24);     press(1, K_R);  drain();
    press(1, K_CF); cyc(2);
    sb_push("n2_win_status", 1, S_STATUS, 40'h00000_00050);
    sb_push("n2_win_ge", 1, S_GE, 1);
    sb_push("n2_win_player", 1, S_PLAYER, 0);   drain();
    sb_push("n2_end_left", 1, S_CSEL, 24);      press(1, K_L);  drain();
    sb_push("n2_end_confirm", 1, S_GE, 1);
    sb_push("n2_end_cf_status", 1, S_STATUS, 40'h00000_00050); press(1, K_CF); drain();
    sb_push("n2_end_cancel", 1, S_SELING, 1);   press(1, K_CN); drain();
    sb_push("n2_restart_status", 1, S_STATUS, 40'h00055_00055);
    sb_push("n2_restart_ge", 1, S_GE, 0);
    sb_push("n2_restart_seling", 1, S_SELING, 0); press(1, K_RS); drain();

    // ---- instance 2: single-pile rows ----
    sb_push("n1_left", 2, S_CSEL, 0);           press(2, K_L);  drain();
    sb_push("n1_right", 2, S_CSEL, 0);          press(2, K_R);  drain();
    sb_push("n1_src", 2, S_CSEL, 20);           press(2, K_CF); drain();
    sb_push("n1_dst_left", 2, S_CSEL, 20);      press(2, K_L);  drain();
    press(2, K_CF); cyc(2);
    sb_push("n1_win_status", 2, S_STATUS, 40'h00000_00005);
    sb_push("n1_win_ge", 2, S_GE, 1);           drain();
    sb_push("n1_end_left", 2, S_CSEL, 20);      press(2, K_L);  drain();
    sb_push("n1_end_cf", 2, S_GE, 1);           press(2, K_CF); drain();
    sb_push("n1_restart_status", 2, S_STATUS, 40'h00005_00005);
    sb_push("n1_restart_ge", 2, S_GE, 0);
    sb_push("n1_restart_player", 2, S_PLAYER, 0); press(2, K_RS); drain();

    // ---- reset during APPLY discards the move ----
    press(0, K_RS);
    press(0, K_CF);
    press(0, K_CF);
    vga_rst_n = 1'b0;
    cyc(1);
    vga_rst_n = 1'b1;
    cyc(2);
    sb_push("rst_mid_status", 0, S_STATUS, 40'h11111_11111);
    sb_push("rst_mid_player", 0, S_PLAYER, 0);
    sb_push("rst_mid_seling", 0, S_SELING, 0);
    sb_push("rst_mid_csel", 0, S_CSEL, 0);      drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
